// File: rtl/l2_writeback_buffer.sv
// rtl/l2_writeback_buffer.sv - L2 victim writeback FIFO draining to DRAM over AXI AW/W/B
module l2_writeback_buffer #(
    parameter int DEPTH     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [31:0]              wb_addr,
    input  logic [511:0]             wb_data,
    input  logic [31:0]              lk_addr,
    output logic                     lk_hit,
    output logic [511:0]             lk_data,
    output logic [31:0]              aw_addr,
    output logic                     aw_valid,
    input  logic                     aw_ready,
    output logic [7:0]               aw_len,
    output logic [2:0]               aw_size,
    output logic [1:0]               aw_burst,
    output logic [511:0]             w_data,
    output logic [63:0]              w_strb,
    output logic                     w_last,
    output logic                     w_valid,
    input  logic                     w_ready,
    input  logic                     b_valid,
    input  logic [1:0]               b_resp,
    output logic                     b_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_sticky
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEND   = 2'd1;
    localparam logic [1:0] WAIT_B = 2'd2;

    logic [25:0]   addr_mem [DEPTH];
    logic [511:0]  data_mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] lk_idx;
    logic [1:0]    state;
    logic          aw_done;
    logic          w_done;
    logic [RW-1:0] retries;

    logic push;
    logic pop;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic b_ok;
    logic retry_left;
    logic unused_bits;

    assign unused_bits = ^{wb_addr[5:0], lk_addr[5:0]};

    assign wb_ready   = (count < CW'(DEPTH));
    assign push       = wb_valid && wb_ready;
    assign aw_hs      = aw_valid && aw_ready;
    assign w_hs       = w_valid && w_ready;
    assign b_ready    = (state == WAIT_B);
    assign b_hs       = b_valid && b_ready;
    assign b_ok       = (b_resp == 2'b00);
    assign retry_left = (retries < RW'(MAX_RETRY));
    // Head leaves the FIFO on success or once its retry budget is exhausted
    assign pop        = b_hs && (b_ok || !retry_left);

    assign aw_addr  = {addr_mem[head], 6'b0};
    assign w_data   = data_mem[head];
    assign aw_len   = 8'd0;
    assign aw_size  = 3'b110;
    assign aw_burst = 2'b01;
    assign w_strb   = {64{1'b1}};
    assign w_last   = 1'b1;

    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem[tail] <= wb_addr[31:6];
            data_mem[tail] <= wb_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            aw_valid   <= 1'b0;
            w_valid    <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            retries    <= '0;
            err_sticky <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state    <= SEND;
                        aw_valid <= 1'b1;
                        w_valid  <= 1'b1;
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                    end
                end
                SEND: begin
                    if (aw_hs) begin
                        aw_valid <= 1'b0;
                        aw_done  <= 1'b1;
                    end
                    if (w_hs) begin
                        w_valid <= 1'b0;
                        w_done  <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) state <= WAIT_B;
                end
                WAIT_B: begin
                    if (b_hs) begin
                        if (b_ok) begin
                            retries <= '0;
                            state   <= IDLE;
                        end else if (retry_left) begin
                            retries  <= retries + 1'b1;
                            state    <= SEND;
                            aw_valid <= 1'b1;
                            w_valid  <= 1'b1;
                            aw_done  <= 1'b0;
                            w_done   <= 1'b0;
                        end else begin
                            retries    <= '0;
                            err_sticky <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Scan oldest to youngest so the last match left standing is the youngest
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        lk_idx  = head;
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = head + AW'(i);
            if ((CW'(i) < count) && (addr_mem[lk_idx] == lk_addr[31:6])) begin
                lk_hit  = 1'b1;
                lk_data = data_mem[lk_idx];
            end
        end
    end

endmodule

// File: tb/tb_l2_writeback_buffer.sv
// tb/tb_l2_writeback_buffer.sv - bench for l2_writeback_buffer against a queue-based reference model
module tb_l2_writeback_buffer;

    localparam int DEPTH     = 4;
    localparam int MAX_RETRY = 3;

    logic         clock;
    logic         reset;
    logic         wb_valid;
    logic         wb_ready;
    logic [31:0]  wb_addr;
    logic [511:0] wb_data;
    logic [31:0]  lk_addr;
    logic         lk_hit;
    logic [511:0] lk_data;
    logic [31:0]  aw_addr;
    logic         aw_valid;
    logic         aw_ready;
    logic [7:0]   aw_len;
    logic [2:0]   aw_size;
    logic [1:0]   aw_burst;
    logic [511:0] w_data;
    logic [63:0]  w_strb;
    logic         w_last;
    logic         w_valid;
    logic         w_ready;
    logic         b_valid;
    logic [1:0]   b_resp;
    logic         b_ready;
    logic [2:0]   count;
    logic         err_sticky;

    l2_writeback_buffer #(.DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY)) dut (
        .clock(clock), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
        .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
        .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready),
        .count(count), .err_sticky(err_sticky)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model: the buffer as an ordered list of lines plus per-attempt handshake flags
    logic [25:0]  m_addr [$];
    logic [511:0] m_data [$];
    int           m_retry;
    bit           aw_seen, w_seen, m_err;
    bit           aw_pend, w_pend;
    int           aw_issues;

    logic [31:0]  pool [4] = '{32'h0000_1000, 32'h0000_1040, 32'h0000_2000, 32'h0000_2040};
    logic [511:0] pat_a = {16{32'hA5A5_0001}};
    logic [511:0] pat_b = {16{32'h5A5A_0002}};

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] d;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic model_clear();
        m_addr.delete();
        m_data.delete();
        m_retry = 0;
        aw_seen = 0; w_seen = 0; m_err = 0;
        aw_pend = 0; w_pend = 0;
    endtask

    // Called at a falling edge with inputs already applied; checks, predicts the next rising edge, then advances
    task automatic cycle();
        bit           hit;
        logic [511:0] ld;
        bit           can_push;
        #1;
        check("count", count, m_addr.size());
        check("wb_ready", wb_ready, m_addr.size() < DEPTH);
        check("err_sticky", err_sticky, m_err);
        check("b_ready", b_ready, aw_seen && w_seen);
        hit = 0; ld = '0;
        foreach (m_addr[i]) if (m_addr[i] == lk_addr[31:6]) begin hit = 1; ld = m_data[i]; end
        check("lk_hit", lk_hit, hit);
        if (hit) check("lk_data", lk_data, ld);
        if (aw_pend) check("aw_hold", aw_valid, 1);
        if (w_pend)  check("w_hold", w_valid, 1);
        if (aw_valid) begin
            check("aw_after_hs", aw_seen, 0);
            check("aw_nonempty", m_addr.size() > 0, 1);
            if (m_addr.size() > 0) check("aw_addr", aw_addr, {m_addr[0], 6'b0});
            check("aw_len", aw_len, 0);
            check("aw_size", aw_size, 6);
            check("aw_burst", aw_burst, 1);
        end
        if (w_valid) begin
            check("w_after_hs", w_seen, 0);
            if (m_data.size() > 0) check("w_data", w_data, m_data[0]);
            check("w_strb", w_strb, {64{1'b1}});
            check("w_last", w_last, 1);
        end
        aw_pend  = aw_valid && !aw_ready;
        w_pend   = w_valid && !w_ready;
        can_push = m_addr.size() < DEPTH;
        if (aw_valid && aw_ready) begin aw_seen = 1; aw_issues++; end
        if (w_valid && w_ready) w_seen = 1;
        if (b_valid && b_ready) begin
            aw_seen = 0; w_seen = 0;
            if (b_resp == 2'b00 || m_retry == MAX_RETRY) begin
                if (b_resp != 2'b00) m_err = 1;
                void'(m_addr.pop_front());
                void'(m_data.pop_front());
                m_retry = 0;
            end else begin
                m_retry++;
            end
        end
        if (wb_valid && can_push) begin
            m_addr.push_back(wb_addr[31:6]);
            m_data.push_back(wb_data);
        end
        @(negedge clock);
    endtask

    task automatic drain(input int budget);
        int n;
        wb_valid = 0; aw_ready = 1; w_ready = 1; b_valid = 1; b_resp = 2'b00;
        n = 0;
        while ((m_addr.size() > 0 || count != 0) && n < budget) begin cycle(); n++; end
        check("drain_done", count, 0);
    endtask

    initial begin
        reset = 0; wb_valid = 0; wb_addr = '0; wb_data = '0; lk_addr = 32'h0000_1040;
        aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 2'b00;
        aw_issues = 0;
        model_clear();
        @(negedge clock);
        #1;
        check("rst_aw_valid", aw_valid, 0);
        check("rst_w_valid", w_valid, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_wb_ready", wb_ready, 1);
        check("rst_lk_hit", lk_hit, 0);
        check("rst_count", count, 0);
        check("rst_err", err_sticky, 0);
        reset = 1;
        @(negedge clock);

        // Single line, zero-wait DRAM
        wb_valid = 1; wb_addr = 32'h0000_1040; wb_data = pat_a;
        aw_ready = 1; w_ready = 1; b_valid = 1; b_resp = 2'b00;
        cycle();
        wb_valid = 0;
        repeat (6) cycle();
        check("t1_issues", aw_issues, 1);

        // Fill with DRAM stalled; fifth push must be held
        aw_ready = 0; w_ready = 0; b_valid = 0;
        for (int i = 0; i < 5; i++) begin
            wb_valid = 1; wb_addr = pool[i % 4] + 32'(i); wb_data = rnd512();
            cycle();
        end
        check("full_wb_ready", wb_ready, 0);
        drain(60);

        // Duplicate address: youngest wins
        aw_ready = 0; w_ready = 0; b_valid = 0;
        wb_valid = 1; wb_addr = 32'h0000_2000; wb_data = pat_a; cycle();
        wb_addr = 32'h0000_2000; wb_data = pat_b; cycle();
        wb_valid = 0; lk_addr = 32'h0000_2010; cycle();
        #1;
        check("lk_young_hit", lk_hit, 1);
        check("lk_young_data", lk_data, pat_b);
        @(negedge clock);
        lk_addr = 32'h0000_3000; cycle();

        // W accepted well before AW
        w_ready = 1; repeat (3) cycle();
        aw_ready = 1; b_valid = 1; repeat (4) cycle();
        drain(40);

        // Four error responses drop the head; the next entry drains normally
        aw_ready = 1; w_ready = 1; b_valid = 1; b_resp = 2'b10; aw_issues = 0;
        wb_valid = 1; wb_addr = 32'h0000_4000; wb_data = pat_a; cycle();
        wb_addr = 32'h0000_5000; wb_data = pat_b; cycle();
        wb_valid = 0;
        for (int n = 0; n < 40 && !m_err; n++) cycle();
        check("err_issues", aw_issues, 4);
        check("err_model_set", err_sticky, 1);
        b_resp = 2'b00;
        repeat (8) cycle();
        check("err_next_issues", aw_issues, 5);
        drain(20);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            wb_valid = 1'($urandom_range(0, 1));
            wb_addr  = pool[$urandom_range(0, 3)] + 32'($urandom_range(0, 63));
            wb_data  = rnd512();
            lk_addr  = pool[$urandom_range(0, 3)] + 32'($urandom_range(0, 63));
            aw_ready = ($urandom_range(0, 2) != 0);
            w_ready  = ($urandom_range(0, 2) != 0);
            b_valid  = 1'($urandom_range(0, 1));
            b_resp   = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00;
            cycle();
        end
        drain(300);

        // Reset in WAIT_B with two lines queued
        aw_ready = 1; w_ready = 1; b_valid = 0;
        wb_valid = 1; wb_addr = 32'h0000_6000; wb_data = pat_a; cycle();
        wb_addr = 32'h0000_7000; wb_data = pat_b; cycle();
        wb_valid = 0; lk_addr = 32'h0000_7000;
        for (int n = 0; n < 20 && !b_ready; n++) cycle();
        check("reached_wait_b", b_ready, 1);
        #2 reset = 0;
        #1;
        check("arst_aw_valid", aw_valid, 0);
        check("arst_w_valid", w_valid, 0);
        check("arst_b_ready", b_ready, 0);
        check("arst_count", count, 0);
        check("arst_wb_ready", wb_ready, 1);
        check("arst_lk_hit", lk_hit, 0);
        model_clear();
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        repeat (3) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/l2_writeback_buffer.md
Name: l2_writeback_buffer

Overview:
- Sits directly downstream of the L2 cache on its DRAM side; accepts dirty 64-byte victim lines and writes them to DRAM over the AXI AW/W/B channels.
- Holds victims in an in-order FIFO until DRAM returns a write response.
- Provides a combinational address lookup so the L2 miss path can forward a victim line that has not yet reached DRAM.

Parameters:
DEPTH, 4, number of victim line entries (power of two, >=2)
MAX_RETRY, 3, number of re-issues after an error response before the entry is dropped

Ports:
clock  input  1  single clock, all state on rising edge
reset  input  1  asynchronous active-low reset
wb_valid  input  1  L2 presents a victim line
wb_ready  output  1  buffer accepts the victim this cycle
wb_addr  input  32  victim address (bits [5:0] ignored)
wb_data  input  512  victim line
lk_addr  input  32  L2 miss lookup address
lk_hit  output  1  a buffered entry matches lk_addr[31:6]
lk_data  output  512  line of the youngest matching entry
aw_addr  output  32  write address, {addr[31:6],6'b0}
aw_valid  output  1  write address valid
aw_ready  input  1  DRAM accepts address
aw_len  output  8  constant 0
aw_size  output  3  constant 3'b110 (64 B)
aw_burst  output  2  constant 2'b01 (INCR)
w_data  output  512  write data
w_strb  output  64  constant all ones
w_last  output  1  constant 1
w_valid  output  1  write data valid
w_ready  input  1  DRAM accepts data
b_valid  input  1  DRAM response valid
b_resp  input  2  00 OKAY, otherwise error
b_ready  output  1  buffer accepts response
count  output  $clog2(DEPTH)+1  occupied entries
err_sticky  output  1  an entry was dropped after MAX_RETRY failures

Behaviour:
Reset (reset low, asynchronous):
- FIFO empty; FSM in IDLE; count=0; err_sticky=0.
- aw_valid=0, w_valid=0, b_ready=0, wb_ready=1, lk_hit=0.

Enqueue:
- wb_ready = (count<DEPTH). This is registered-state based only; there is no same-cycle pass-through when full.
- wb_valid&&wb_ready writes the tail entry and advances the tail pointer (wraps modulo DEPTH).
- A duplicate address is allowed; both entries drain in order.

Lookup:
- Purely combinational over all occupied entries, including the head entry currently in flight.
- With several matches, the youngest (closest to tail) wins.
- An entry being enqueued in the same cycle is not visible until the next cycle.

Drain FSM (head entry only):
- IDLE: if count>0, go to SEND next cycle. aw_valid and w_valid rise together and are driven from the head entry.
- SEND: aw and w complete independently; aw_done/w_done flags are set on their respective handshakes. Each valid drops in the cycle after its own handshake. Once both are done (possibly in the same cycle), go to WAIT_B.
- WAIT_B: b_ready=1. On b_valid:
  - OKAY: pop head (head pointer wraps), clear retry counter, go to IDLE.
  - error with retries<MAX_RETRY: retries++, go to SEND and re-issue the same entry.
  - error with retries==MAX_RETRY: pop head, set err_sticky, go to IDLE.
- Minimum drain latency with ready/response in zero wait cycles: 3 cycles from entry occupied to pop.
- AXI stability: aw_valid and w_valid, once high, are never deasserted before their handshake. Address and data stay stable while valid.
- Simultaneous push and pop: count unchanged; both pointers advance.
- count updates the cycle after the push/pop handshake.
- b_valid outside WAIT_B is ignored (b_ready=0).
- Reset asserted mid-transaction: all entries discarded; outputs return to reset values immediately.

Test Plan:
- Push addr 0x0000_1040, data pattern A; aw_ready=w_ready=1, b_valid one cycle later with OKAY -> one AW with aw_addr=0x0000_1040, aw_len=0, aw_size=6, w_last=1, w_strb all ones; count returns 0.
- Push 4 lines with DRAM stalled (aw_ready=0) -> wb_ready=0 after the 4th push; a 5th wb_valid is held; lines drain in push order once stalls release.
- Two pushes to 0x2000 with data A then B, then lk_addr=0x2010 -> lk_hit=1, lk_data=B; lk_addr=0x3000 -> lk_hit=0.
- w_ready=1 two cycles before aw_ready=1 -> w_valid drops the cycle after its handshake, aw_valid stays high until accepted; single b_ready phase follows.
- b_resp=2'b10 four consecutive times with MAX_RETRY=3 -> 4 AW issues of the same address, then pop, err_sticky=1; the next entry drains normally.
- Reset asserted during WAIT_B with 2 entries queued -> aw_valid=w_valid=b_ready=0, count=0, wb_ready=1 asynchronously.
